// File: rtl/mips_pkg.sv
// Shared widths for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PC_W       = 10;

endpackage : mips_pkg

// File: rtl/data_ram.sv
// Word-addressed data RAM: asynchronous read port, write on the falling clock edge.
module data_ram
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 writeEnable,
  input  logic [ADDR_BITS-1:0] writeIndex,
  input  logic [WORD_W-1:0]    writeWord,
  input  logic [ADDR_BITS-1:0] readIndex,
  output logic [WORD_W-1:0]    readWord_c
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  // Contents start at zero and are deliberately untouched by reset.
  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(negedge clock) begin
    if (writeEnable) begin
      mem[writeIndex] <= writeWord;
    end
  end

  assign readWord_c = mem[readIndex];

endmodule : data_ram

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, word load/store against data_ram, and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inBranch,
  input  logic                  inMemRead,
  input  logic                  inMemWrite,
  input  logic                  inMemToReg,
  input  logic                  inRegWrite,
  input  logic                  zero,
  input  logic [PC_W-1:0]       inPC,
  input  logic [WORD_W-1:0]     aluResult,
  input  logic [WORD_W-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] wr,
  output logic                  PCSrc,
  output logic [PC_W-1:0]       branchTarget,
  output logic [WORD_W-1:0]     aluResult_MEMEXE,
  output logic [WORD_W-1:0]     readData,
  output logic [WORD_W-1:0]     outAluResult,
  output logic [REG_ADDR_W-1:0] outWr,
  output logic                  outMemToReg,
  output logic                  outRegWrite,
  output logic                  memError
);

  logic                 addrAligned;
  logic                 addrInRange;
  logic                 addrValid;
  logic                 memAccess;
  logic                 ramWriteEnable;
  logic [ADDR_BITS-1:0] wordIndex;
  logic [WORD_W-1:0]    ramReadWord;

  assign PCSrc            = inBranch & zero & ~reset;
  assign branchTarget     = inPC;
  assign aluResult_MEMEXE = aluResult;

  // Only aligned byte addresses that fall inside the RAM are legal.
  assign addrAligned    = (aluResult[1:0] == 2'b00);
  assign addrInRange    = ((aluResult >> (ADDR_BITS + 2)) == '0);
  assign addrValid      = addrAligned & addrInRange;
  assign wordIndex      = aluResult[ADDR_BITS+1:2];
  assign memAccess      = inMemRead | inMemWrite;
  assign ramWriteEnable = inMemWrite & addrValid & ~reset;

  data_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_dataRam (
    .clock      (clock),
    .writeEnable(ramWriteEnable),
    .writeIndex (wordIndex),
    .writeWord  (writeData),
    .readIndex  (wordIndex),
    .readWord_c (ramReadWord)
  );

  // MEM/WB register; the read sees pre-store content when read and write share a cycle.
  always_ff @(negedge clock) begin
    if (reset) begin
      readData     <= '0;
      outAluResult <= '0;
      outWr        <= '0;
      outMemToReg  <= 1'b0;
      outRegWrite  <= 1'b0;
      memError     <= 1'b0;
    end else begin
      readData     <= (inMemRead && addrValid) ? ramReadWord : '0;
      outAluResult <= aluResult;
      outWr        <= wr;
      outMemToReg  <= inMemToReg;
      outRegWrite  <= inRegWrite;
      if (memAccess && !addrValid) begin
        memError <= 1'b1;
      end
    end
  end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed EX/MEM traffic against a word-array model.
module tb_mem_stage;

  localparam int DEPTH = 256;

  logic        clock;
  logic        reset;
  logic        inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite, zero;
  logic [9:0]  inPC;
  logic [31:0] aluResult, writeData;
  logic [4:0]  wr;
  logic        PCSrc;
  logic [9:0]  branchTarget;
  logic [31:0] aluResult_MEMEXE, readData, outAluResult;
  logic [4:0]  outWr;
  logic        outMemToReg, outRegWrite, memError;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wrReg;
    logic        m2r;
    logic        rw;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] modelMem [DEPTH];
  logic        modelErr;
  int          checkCount = 0;
  int          passCount  = 0;

  mem_stage #(.ADDR_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .inBranch(inBranch), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inMemToReg(inMemToReg), .inRegWrite(inRegWrite), .zero(zero),
    .inPC(inPC), .aluResult(aluResult), .writeData(writeData), .wr(wr),
    .PCSrc(PCSrc), .branchTarget(branchTarget), .aluResult_MEMEXE(aluResult_MEMEXE),
    .readData(readData), .outAluResult(outAluResult), .outWr(outWr),
    .outMemToReg(outMemToReg), .outRegWrite(outRegWrite), .memError(memError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one EX/MEM beat at posedge, check combinational outputs, push the MEM/WB expectation.
  task automatic issue(input logic rst, input logic br, input logic z, input logic [9:0] pc,
                       input logic rd, input logic wrt, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] wreg);
    exp_t e;
    logic valid;
    int   idx;
    @(posedge clock);
    reset = rst; inBranch = br; zero = z; inPC = pc; inMemRead = rd; inMemWrite = wrt;
    inMemToReg = m2r; inRegWrite = rw; aluResult = alu; writeData = wdata; wr = wreg;
    #1;
    chk("PCSrc", 32'(PCSrc), 32'(br & z & ~rst));
    chk("branchTarget", 32'(branchTarget), 32'(pc));
    chk("aluResult_MEMEXE", aluResult_MEMEXE, alu);
    valid = (alu % 4 == 0) && (alu < 32'(4 * DEPTH));
    idx   = int'(alu >> 2) % DEPTH;
    if (rst) begin
      modelErr = 1'b0;
      e = '{rd: 32'h0, alu: 32'h0, wrReg: 5'h0, m2r: 1'b0, rw: 1'b0, err: 1'b0};
    end else begin
      e.rd = (rd && valid) ? modelMem[idx] : 32'h0;
      if (wrt && valid) modelMem[idx] = wdata;
      if ((rd || wrt) && !valid) modelErr = 1'b1;
      e.alu = alu; e.wrReg = wreg; e.m2r = m2r; e.rw = rw; e.err = modelErr;
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 10'h0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
  endtask

  // Monitor: every falling edge the MEM/WB register presents one result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("readData", readData, e.rd);
        chk("outAluResult", outAluResult, e.alu);
        chk("outWr", 32'(outWr), 32'(e.wrReg));
        chk("outMemToReg", 32'(outMemToReg), 32'(e.m2r));
        chk("outRegWrite", 32'(outRegWrite), 32'(e.rw));
        chk("memError", 32'(memError), 32'(e.err));
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;
    modelErr = 1'b0;
    reset = 1'b1; inBranch = 0; zero = 0; inPC = 0; inMemRead = 0; inMemWrite = 0;
    inMemToReg = 0; inRegWrite = 0; aluResult = 0; writeData = 0; wr = 0;

    // Reset with a pending store to 0x10; RAM[4] must stay zero.
    issue(1, 0, 0, 10'h0, 0, 1, 0, 0, 32'h10, 32'hFFFF_FFFF, 5'h3);
    issue(1, 0, 0, 10'h0, 0, 1, 0, 0, 32'h10, 32'hFFFF_FFFF, 5'h3);
    issue(0, 0, 0, 10'h0, 1, 0, 1, 1, 32'h10, 32'h0, 5'h4);
    // Store then load.
    issue(0, 0, 0, 10'h0, 0, 1, 0, 0, 32'h8, 32'hDEAD_BEEF, 5'h0);
    issue(0, 0, 0, 10'h0, 1, 0, 1, 1, 32'h8, 32'h0, 5'h9);
    // Same-cycle read and write returns the old word.
    issue(0, 0, 0, 10'h0, 1, 1, 1, 1, 32'h8, 32'h1234_5678, 5'h9);
    issue(0, 0, 0, 10'h0, 1, 0, 1, 1, 32'h8, 32'h0, 5'h9);
    // Branch taken then not taken.
    issue(0, 1, 1, 10'h2A, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    issue(0, 1, 0, 10'h2A, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    // Misaligned load sets a sticky error.
    issue(0, 0, 0, 10'h0, 1, 0, 1, 1, 32'h6, 32'h0, 5'h2);
    idle(5);
    // Out-of-range store aliases index 0 in its low bits but must not write.
    issue(0, 0, 0, 10'h0, 0, 1, 0, 0, 32'h400, 32'h5555_AAAA, 5'h0);
    issue(0, 0, 0, 10'h0, 1, 0, 1, 1, 32'h0, 32'h0, 5'h1);
    issue(1, 0, 0, 10'h0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    idle(1);
    // Pass-through with no memory operation.
    issue(0, 0, 0, 10'h0, 0, 0, 0, 1, 32'hCAFE_0000, 32'h0, 5'd17);

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 6)      a = 32'($urandom_range(0, 15)) << 2;
      else if (kind == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (kind == 8) a = 32'($urandom_range(0, 255)) << 2 | (32'h400 << $urandom_range(0, 21));
      else                a = $urandom;
      issue(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 10'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
    end

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clock);
    #2;
    chk("scoreboard_drain", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_mem_stage
